// File: rtl/md_pkg.sv
// Shared encodings, FSM states and helpers for the HI/LO multiply/divide unit.
// Optional MD_DIV0_FAST_EN shortcut lives in md_sequencer.
package md_pkg;

   localparam logic [2:0] MD_NONE = 3'd0;
   localparam logic [2:0] MD_MTHI = 3'd1;
   localparam logic [2:0] MD_MTLO = 3'd2;
   localparam logic [2:0] MD_MUL  = 3'd3;
   localparam logic [2:0] MD_DIV  = 3'd4;

   localparam int DIV_STEPS = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_FIX
   } md_state_t;

   function automatic logic [31:0] md_mag(
      input logic [31:0] v,
      input logic        s
   );
      return (s && v[31]) ? -v : v;
   endfunction

endpackage

// File: rtl/md_div_core.sv
// Iterative restoring divider: one quotient bit per enabled cycle.
// Remainder and dividend/quotient share a shift pair.
module md_div_core
   import md_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        en,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quo,
   output logic [31:0] rem
);

   logic [31:0] dvs;
   logic [32:0] trial;

   assign trial = {rem, quo[31]} - {1'b0, dvs};

   always_ff @(posedge clk) begin
      if (reset) begin
         quo <= '0;
         rem <= '0;
         dvs <= '0;
      end else if (load) begin
         quo <= dividend;
         rem <= '0;
         dvs <= divisor;
      end else if (en) begin
         // non-negative trial keeps the subtraction
         if (!trial[32]) begin
            rem <= trial[31:0];
            quo <= {quo[30:0], 1'b1};
         end else begin
            rem <= {rem[30:0], quo[31]};
            quo <= {quo[30:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/md_sequencer.sv
// EX-stage multiply/divide sequencer owning HI/LO; raises md_stall for ID users.
// MD_DIV0_FAST_EN: divide by zero skips the iterations and commits at once.
module md_sequencer
   import md_pkg::*;
#(
   parameter int MUL_LAT = 4
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [2:0]  md_func,
   input  logic        md_sign,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        id_md_use,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
   localparam logic [4:0] DIV_LAST = 5'(DIV_STEPS - 1);

   md_state_t   state, state_n;
   logic [4:0]  cnt;
   logic [31:0] a_q, b_q;
   logic        sgn_q, sa_q, sb_q, z_q;
   logic        is_mul, is_div, start, div0;
   logic [63:0] ax, bx, prod;
   logic [31:0] quo, rem, q_fix, r_fix;

   assign is_mul = (md_func == MD_MUL);
   assign is_div = (md_func == MD_DIV);
   assign start  = ex_valid && (state == S_IDLE)
                   && (is_mul || is_div);

`ifdef MD_DIV0_FAST_EN
   assign div0 = (rt_val == 32'd0);
`else
   assign div0 = 1'b0;
`endif

   assign busy     = (state != S_IDLE);
   assign md_stall = id_md_use && (busy || start);

   assign ax    = {{32{sgn_q & a_q[31]}}, a_q};
   assign bx    = {{32{sgn_q & b_q[31]}}, b_q};
   assign prod  = ax * bx;
   assign q_fix = (sa_q ^ sb_q) ? -quo : quo;
   assign r_fix = sa_q ? -rem : rem;

   md_div_core u_div (
      .clk      (clk),
      .reset    (reset),
      .load     (start && is_div),
      .en       (state == S_DIV),
      .dividend (md_mag(rs_val, md_sign)),
      .divisor  (md_mag(rt_val, md_sign)),
      .quo      (quo),
      .rem      (rem)
   );

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:
            if (start)
               state_n = is_mul ? S_MUL
                       : (div0 ? S_FIX : S_DIV);
         S_MUL: if (cnt == MUL_LAST) state_n = S_IDLE;
         S_DIV: if (cnt == DIV_LAST) state_n = S_FIX;
         S_FIX: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         sgn_q <= 1'b0;
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
         z_q   <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_n;
         if (state_n != state)
            cnt <= '0;
         else if (state != S_IDLE)
            cnt <= cnt + 5'd1;
         if (start) begin
            a_q   <= rs_val;
            b_q   <= rt_val;
            sgn_q <= md_sign;
            sa_q  <= md_sign & rs_val[31];
            sb_q  <= md_sign & rt_val[31];
            z_q   <= div0;
         end
         if (ex_valid && state == S_IDLE) begin
            if (md_func == MD_MTHI) hi <= rs_val;
            if (md_func == MD_MTLO) lo <= rs_val;
         end
         if (state == S_MUL && cnt == MUL_LAST)
            {hi, lo} <= prod;
         // a fast zero divide commits the raw dividend unsigned
         if (state == S_FIX) begin
            hi <= z_q ? a_q : r_fix;
            lo <= z_q ? 32'hFFFF_FFFF : q_fix;
         end
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed vector bench for md_sequencer (MUL_LAT=4).
// Divide-by-zero expectations follow MD_DIV0_FAST_EN.
module tb_md_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic [2:0]  md_func;
   logic        md_sign;
   logic [31:0] rs_val, rt_val;
   logic        id_md_use;
   logic        busy, md_stall;
   logic [31:0] hi, lo;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   md_sequencer #(.MUL_LAT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .ex_valid  (ex_valid),
      .md_func   (md_func),
      .md_sign   (md_sign),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .id_md_use (id_md_use),
      .busy      (busy),
      .md_stall  (md_stall),
      .hi        (hi),
      .lo        (lo)
   );

   always @(posedge clk)
      assert (!(ex_valid && busy && md_func inside {3'd1, 3'd2}))
      else $error("mthi/mtlo issued while busy");

   typedef struct {
      string       name;
      logic [2:0]  func;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
      int          ecyc;
   } vec_t;

`ifdef MD_DIV0_FAST_EN
   localparam int          D0C  = 1;
   localparam logic [31:0] SZHI = 32'hFFFF_FFFB;
   localparam logic [31:0] SZLO = 32'hFFFF_FFFF;
`else
   localparam int          D0C  = 33;
   localparam logic [31:0] SZHI = 32'hFFFF_FFFB;
   localparam logic [31:0] SZLO = 32'h0000_0001;
`endif

   vec_t v[12];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] f, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
      ex_valid = 1'b1;
      md_func  = f;
      md_sign  = s;
      rs_val   = a;
      rt_val   = b;
      tick();
      ex_valid = 1'b0;
      md_func  = 3'd0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
   endtask

   int nb;

   initial begin
      v[0]  = '{"mthi",      3'd1, 1'b0, 32'h1234_5678, 32'h0,
                32'h1234_5678, 32'h0, 0};
      v[1]  = '{"mtlo",      3'd2, 1'b0, 32'h9ABC_DEF0, 32'h0,
                32'h1234_5678, 32'h9ABC_DEF0, 0};
      v[2]  = '{"func5",     3'd5, 1'b1, 32'hDEAD_BEEF, 32'h1,
                32'h1234_5678, 32'h9ABC_DEF0, 0};
      v[3]  = '{"mul_s",     3'd3, 1'b1, 32'hFFFF_FFFD, 32'd7,
                32'hFFFF_FFFF, 32'hFFFF_FFEB, 4};
      v[4]  = '{"mul_u",     3'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFE, 32'h0000_0001, 4};
      v[5]  = '{"mul_s_max", 3'd3, 1'b1, 32'h7FFF_FFFF, 32'd2,
                32'h0, 32'hFFFF_FFFE, 4};
      v[6]  = '{"div_s",     3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
      v[7]  = '{"div_ovf",   3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h0, 32'h8000_0000, 33};
      v[8]  = '{"div_u",     3'd4, 1'b0, 32'd100, 32'd7,
                32'd2, 32'd14, 33};
      v[9]  = '{"div_s_nb",  3'd4, 1'b1, 32'd7, 32'hFFFF_FFFE,
                32'd1, 32'hFFFF_FFFD, 33};
      v[10] = '{"div0_u",    3'd4, 1'b0, 32'd5, 32'd0,
                32'd5, 32'hFFFF_FFFF, D0C};
      v[11] = '{"div0_s",    3'd4, 1'b1, 32'hFFFF_FFFB, 32'd0,
                SZHI, SZLO, D0C};

      reset     = 1'b1;
      ex_valid  = 1'b0;
      md_func   = 3'd0;
      md_sign   = 1'b0;
      rs_val    = '0;
      rt_val    = '0;
      id_md_use = 1'b1;
      repeat (3) tick();
      chk("rst_busy",  {31'b0, busy}, 32'd0);
      chk("rst_stall", {31'b0, md_stall}, 32'd0);
      chk("rst_hi",    hi, 32'd0);
      chk("rst_lo",    lo, 32'd0);
      reset     = 1'b0;
      id_md_use = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) begin
         issue(v[i].func, v[i].sgn, v[i].a, v[i].b);
         count_busy(nb);
         chk({v[i].name, "_cyc"}, nb, v[i].ecyc);
         chk({v[i].name, "_hi"}, hi, v[i].ehi);
         chk({v[i].name, "_lo"}, lo, v[i].elo);
         tick();
      end

      // stall window around an unsigned divide with mflo waiting in ID
      id_md_use = 1'b1;
      ex_valid  = 1'b1;
      md_func   = 3'd4;
      md_sign   = 1'b0;
      rs_val    = 32'd1000;
      rt_val    = 32'd9;
      #1;
      chk("stall_start", {31'b0, md_stall}, 32'd1);
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      md_func  = 3'd0;
      nb = 0;
      while (md_stall && nb < 100) begin
         nb++;
         tick();
      end
      chk("stall_cycles", nb, 32'd33);
      chk("stall_lo", lo, 32'd111);
      chk("stall_hi", hi, 32'd1);
      chk("stall_busy", {31'b0, busy}, 32'd0);
      id_md_use = 1'b0;
      tick();

      // reset at N+10 abandons a divide
      issue(3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2);
      repeat (9) tick();
      chk("mid_busy", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      tick();
      chk("rst_mid_busy", {31'b0, busy}, 32'd0);
      chk("rst_mid_hi", hi, 32'd0);
      chk("rst_mid_lo", lo, 32'd0);
      reset = 1'b0;
      repeat (40) tick();
      chk("rst_late_hi", hi, 32'd0);
      chk("rst_late_lo", lo, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
